rll_sector_read_ctrl: RTL
=========================

RLL_SECTOR_READ_CTRL -- requirements
Module: rll_sector_read_ctrl

Interface
REQ-001 SHALL have parameter SECTOR_BYTES, default 512, data-field payload length in bytes.
REQ-002 SHALL have parameter DAM_WINDOW, default 64, max decoded bytes after an ID match before a data mark is declared missing.
REQ-003 SHALL have parameter INDEX_LIMIT, default 2, index pulses tolerated without a matching ID.
REQ-004 SHALL have ports, one per line:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse, begins a sector read; ignored unless IDLE
- abort  in  1  one-cycle pulse, cancels the active read
- target_cyl  in  10  cylinder to match
- target_head  in  4  head to match
- target_sec  in  8  sector to match
- index_pulse  in  1  one-cycle pulse per revolution
- id_mark, data_mark, deleted_mark  in  1 each  address-mark strobes from the mark detector
- dec_data  in  8  decoded byte from the RLL decoder
- dec_valid  in  1  dec_data strobe
- dec_error  in  1  decoder constraint/decode error strobe
- dec_enable  out  1  enables decoder and mark detector
- out_data  out  8  sector payload byte
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle completion pulse
- status  out  3  result code, valid from done until the next start

Function
REQ-005 SHALL implement states IDLE, WAIT_ID, READ_ID, WAIT_DAM, READ_DATA, FINISH.
REQ-006 IDLE: on start, latch the targets, clear counters and sticky flags, go to WAIT_ID; dec_enable high in every state except IDLE.
REQ-007 WAIT_ID: on id_mark, reset the CRC to 0xFFFF and go to READ_ID; each index_pulse increments idx_cnt; at idx_cnt == INDEX_LIMIT go to FINISH with status 1 (NOT_FOUND), or 2 (ID_CRC) if any ID CRC failed during the search.
REQ-008 READ_ID SHALL capture 6 dec_valid bytes: {6'b0,cyl[9:8]}, cyl[7:0], head (low nibble), sector, CRC_hi, CRC_lo.
REQ-009 After byte 6, a zero CRC-16-CCITT residue (poly 0x1021, init 0xFFFF, MSB-first, over all 6 bytes) plus a field match SHALL go to WAIT_DAM; a bad CRC SHALL set id_crc_seen; a bad CRC or a mismatch SHALL return to WAIT_ID.
REQ-010 WAIT_DAM: data_mark or deleted_mark SHALL reset the CRC, record the deleted flag and go to READ_DATA; id_mark, or DAM_WINDOW dec_valid strobes, SHALL finish with status 3 (NO_DAM).
REQ-011 READ_DATA SHALL forward the first SECTOR_BYTES bytes to out_data/out_valid and SHALL fold all SECTOR_BYTES+2 bytes into the CRC; the 2 CRC bytes are not forwarded.
REQ-012 out_valid SHALL rise on the cycle after dec_valid and SHALL hold with out_data stable until out_valid && out_ready.
REQ-013 A dec_valid arriving while out_valid && !out_ready SHALL drop that byte and finish with status 5 (OVERRUN); a simultaneous accept and new byte is not an overrun.
REQ-014 After the last CRC byte: nonzero residue SHALL give status 4 (DATA_CRC); otherwise status 7 (DELETED_OK) if deleted, else 0 (OK).
REQ-015 dec_error in READ_ID or READ_DATA SHALL finish with status 6 (DECODE_ERR); in WAIT_ID/WAIT_DAM it is ignored.
REQ-016 FINISH SHALL wait until out_valid is low, pulse done for one cycle, then go to IDLE.
REQ-017 An abort in any non-IDLE state SHALL clear out_valid, skip the done pulse and return to IDLE next cycle with status 1; abort wins over a simultaneous completion.
REQ-018 A start while busy SHALL be ignored; index_pulse outside WAIT_ID SHALL be ignored.
REQ-019 Byte counters SHALL be wide enough for SECTOR_BYTES+2 and DAM_WINDOW without wrap.

Reset
REQ-020 Reset SHALL force IDLE, with dec_enable=0, out_valid=0, out_data=0, busy=0, done=0, status=0, all counters, CRC and sticky flags cleared; reset mid-read SHALL discard the transfer without a done pulse.

Structure
REQ-021 A shared package SHALL hold the state enum, status codes (OK=0, NOT_FOUND=1, ID_CRC=2, NO_DAM=3, DATA_CRC=4, OVERRUN=5, DECODE_ERR=6, DELETED_OK=7), the CRC polynomial/init, and the ID field length 6.
REQ-022 The byte-wide CRC SHALL be one sub-module, crc16_ccitt_byte (inputs clear, byte, strobe; output crc).

Verification
REQ-023 Target cyl 0x155/head 3/sec 7; ID bytes 01 55 03 07 + correct CRC; data_mark; 512 bytes 0x00..0xFF repeating + CRC; out_ready=1 -> 512 bytes in order, done, status 0.
REQ-024 First ID has sector 6, second has sector 7 -> the first is skipped silently, status 0, exactly 512 bytes out.
REQ-025 No matching ID, two index pulses -> done 1 cycle after the 2nd pulse, status 1; with one corrupted-CRC matching ID -> status 2.
REQ-026 Last data CRC byte flipped -> all 512 bytes delivered, status 4; deleted_mark with good CRC -> status 7.
REQ-027 out_ready held low for 2 dec_valid strobes -> status 5, held byte unchanged until accepted.
REQ-028 abort at data byte 100 -> out_valid low, no done, busy low within 2 cycles; a following start succeeds with status 0.

Source files
------------

// File: rtl/rll_sector_read_ctrl_pkg.sv
// rtl/rll_sector_read_ctrl_pkg.sv - shared types, status codes and CRC helper for the RLL sector read controller
//
// Contents:
//   state_t        controller FSM states
//   status_t       completion result codes reported on status
//   CRC_POLY/INIT  CRC-16-CCITT polynomial and seed used for ID and data fields
//   ID_LEN         number of bytes in an ID field (4 address bytes + 2 CRC bytes)
//   crc16_update   folds one byte, MSB first, into a running CRC-16-CCITT
package rll_sector_read_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_ID   = 3'd1,
        ST_READ_ID   = 3'd2,
        ST_WAIT_DAM  = 3'd3,
        ST_READ_DATA = 3'd4,
        ST_FINISH    = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        STS_OK         = 3'd0,
        STS_NOT_FOUND  = 3'd1,
        STS_ID_CRC     = 3'd2,
        STS_NO_DAM     = 3'd3,
        STS_DATA_CRC   = 3'd4,
        STS_OVERRUN    = 3'd5,
        STS_DECODE_ERR = 3'd6,
        STS_DELETED_OK = 3'd7
    } status_t;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam int          ID_LEN   = 6;

    // Byte-at-a-time CRC-16-CCITT, no reflection, no final xor. Running the
    // CRC over a field followed by its own big-endian CRC leaves zero.
    function automatic logic [15:0] crc16_update(input logic [15:0] crc_in,
                                                 input logic [7:0]  data);
        logic [15:0] c;
        c = crc_in ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc16_ccitt_byte.sv
// rtl/crc16_ccitt_byte.sv - byte-wide CRC-16-CCITT accumulator
//
// Ports:
//   clk, reset  clock and synchronous active-high reset (CRC register -> 0)
//   clear       reseeds the CRC to CRC_INIT; wins over strobe
//   byte_in     byte to fold in
//   strobe      folds byte_in into the CRC this cycle
//   crc         current CRC register value
module crc16_ccitt_byte
    import rll_sector_read_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    input  logic        strobe,
    output logic [15:0] crc
);

    logic [15:0] crc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q <= 16'h0000;
        end else if (clear) begin
            crc_q <= CRC_INIT;
        end else if (strobe) begin
            crc_q <= crc16_update(crc_q, byte_in);
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/rll_sector_read_ctrl.sv
// rtl/rll_sector_read_ctrl.sv - RLL disk sector read controller: ID search, data mark wait, payload streaming
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   start, abort                     one-cycle command pulses
//   target_cyl/head/sec              address to search for, latched on start
//   index_pulse                      once-per-revolution pulse
//   id_mark, data_mark, deleted_mark address-mark strobes
//   dec_data, dec_valid, dec_error   decoded byte stream and decode error strobe
//   dec_enable                       enables decoder and mark detector
//   out_data, out_valid, out_ready   payload byte stream with holding handshake
//   busy, done, status               activity flag, completion pulse, result code
module rll_sector_read_ctrl
    import rll_sector_read_ctrl_pkg::*;
#(
    parameter int SECTOR_BYTES = 512,
    parameter int DAM_WINDOW   = 64,
    parameter int INDEX_LIMIT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [9:0]  target_cyl,
    input  logic [3:0]  target_head,
    input  logic [7:0]  target_sec,
    input  logic        index_pulse,
    input  logic        id_mark,
    input  logic        data_mark,
    input  logic        deleted_mark,
    input  logic [7:0]  dec_data,
    input  logic        dec_valid,
    input  logic        dec_error,
    output logic        dec_enable,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic [2:0]  status
);

    // One counter serves both the data field (payload + 2 CRC bytes) and the
    // data-mark search window, so it is sized for whichever is larger.
    localparam int CNT_MAX = (SECTOR_BYTES + 2 > DAM_WINDOW) ? SECTOR_BYTES + 2 : DAM_WINDOW;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (INDEX_LIMIT < 1) ? 1 : $clog2(INDEX_LIMIT + 1);

    localparam logic [CNT_W-1:0] PAYLOAD_END = CNT_W'(SECTOR_BYTES);
    localparam logic [CNT_W-1:0] DATA_LAST   = CNT_W'(SECTOR_BYTES + 1);
    localparam logic [CNT_W-1:0] DAM_LAST    = CNT_W'(DAM_WINDOW - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'((INDEX_LIMIT > 0) ? INDEX_LIMIT - 1 : 0);
    localparam logic [2:0]       ID_LAST     = 3'(ID_LEN - 1);

    state_t            state_q, state_d;
    status_t           status_q, status_d;
    logic [9:0]        tgt_cyl_q, tgt_cyl_d;
    logic [3:0]        tgt_head_q, tgt_head_d;
    logic [7:0]        tgt_sec_q, tgt_sec_d;
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [2:0]        id_cnt_q, id_cnt_d;
    logic [IDX_W-1:0]  idx_cnt_q, idx_cnt_d;
    logic              id_crc_seen_q, id_crc_seen_d;
    logic              deleted_q, deleted_d;
    logic [3:0][7:0]   id_buf_q, id_buf_d;
    logic [7:0]        out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;

    logic        crc_clear;
    logic        crc_strobe;
    logic [15:0] crc;
    logic [15:0] crc_next;
    logic        field_match;

    crc16_ccitt_byte u_crc (
        .clk     (clk),
        .reset   (reset),
        .clear   (crc_clear),
        .byte_in (dec_data),
        .strobe  (crc_strobe),
        .crc     (crc)
    );

    // Residue including the byte arriving now; used on the last byte of a
    // field, before the CRC register has absorbed it.
    assign crc_next = crc16_update(crc, dec_data);

    assign field_match = (id_buf_q[0] == {6'b0, tgt_cyl_q[9:8]}) &&
                         (id_buf_q[1] == tgt_cyl_q[7:0])         &&
                         (id_buf_q[2] == {4'b0, tgt_head_q})     &&
                         (id_buf_q[3] == tgt_sec_q);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            status_q      <= STS_OK;
            tgt_cyl_q     <= '0;
            tgt_head_q    <= '0;
            tgt_sec_q     <= '0;
            byte_cnt_q    <= '0;
            id_cnt_q      <= '0;
            idx_cnt_q     <= '0;
            id_crc_seen_q <= 1'b0;
            deleted_q     <= 1'b0;
            id_buf_q      <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            status_q      <= status_d;
            tgt_cyl_q     <= tgt_cyl_d;
            tgt_head_q    <= tgt_head_d;
            tgt_sec_q     <= tgt_sec_d;
            byte_cnt_q    <= byte_cnt_d;
            id_cnt_q      <= id_cnt_d;
            idx_cnt_q     <= idx_cnt_d;
            id_crc_seen_q <= id_crc_seen_d;
            deleted_q     <= deleted_d;
            id_buf_q      <= id_buf_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d       = state_q;
        status_d      = status_q;
        tgt_cyl_d     = tgt_cyl_q;
        tgt_head_d    = tgt_head_q;
        tgt_sec_d     = tgt_sec_q;
        byte_cnt_d    = byte_cnt_q;
        id_cnt_d      = id_cnt_q;
        idx_cnt_d     = idx_cnt_q;
        id_crc_seen_d = id_crc_seen_q;
        deleted_d     = deleted_q;
        id_buf_d      = id_buf_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        crc_clear     = 1'b0;
        crc_strobe    = 1'b0;

        // The output holding register drains in every state, including FINISH.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    tgt_cyl_d     = target_cyl;
                    tgt_head_d    = target_head;
                    tgt_sec_d     = target_sec;
                    byte_cnt_d    = '0;
                    id_cnt_d      = '0;
                    idx_cnt_d     = '0;
                    id_crc_seen_d = 1'b0;
                    deleted_d     = 1'b0;
                    state_d       = ST_WAIT_ID;
                end
            end

            ST_WAIT_ID: begin
                if (id_mark) begin
                    crc_clear = 1'b1;
                    id_cnt_d  = '0;
                    state_d   = ST_READ_ID;
                end else if (index_pulse) begin
                    idx_cnt_d = idx_cnt_q + 1'b1;
                    if (idx_cnt_q == IDX_LAST) begin
                        state_d  = ST_FINISH;
                        status_d = id_crc_seen_q ? STS_ID_CRC : STS_NOT_FOUND;
                    end
                end
            end

            ST_READ_ID: begin
                if (dec_error) begin
                    state_d  = ST_FINISH;
                    status_d = STS_DECODE_ERR;
                end else if (dec_valid) begin
                    crc_strobe = 1'b1;
                    id_cnt_d   = id_cnt_q + 3'd1;
                    if (id_cnt_q < 3'd4) begin
                        id_buf_d[id_cnt_q[1:0]] = dec_data;
                    end
                    if (id_cnt_q == ID_LAST) begin
                        if (crc_next != 16'h0000) begin
                            id_crc_seen_d = 1'b1;
                            state_d       = ST_WAIT_ID;
                        end else if (field_match) begin
                            byte_cnt_d = '0;
                            state_d    = ST_WAIT_DAM;
                        end else begin
                            state_d = ST_WAIT_ID;
                        end
                    end
                end
            end

            ST_WAIT_DAM: begin
                if (data_mark || deleted_mark) begin
                    crc_clear  = 1'b1;
                    deleted_d  = deleted_mark;
                    byte_cnt_d = '0;
                    state_d    = ST_READ_DATA;
                end else if (id_mark) begin
                    // Next sector's header arrived first: this sector has no data field.
                    state_d  = ST_FINISH;
                    status_d = STS_NO_DAM;
                end else if (dec_valid) begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == DAM_LAST) begin
                        state_d  = ST_FINISH;
                        status_d = STS_NO_DAM;
                    end
                end
            end

            ST_READ_DATA: begin
                if (dec_error) begin
                    state_d  = ST_FINISH;
                    status_d = STS_DECODE_ERR;
                end else if (dec_valid) begin
                    if (out_valid_q && !out_ready) begin
                        // Holding register still full: the new byte is lost.
                        state_d  = ST_FINISH;
                        status_d = STS_OVERRUN;
                    end else begin
                        crc_strobe = 1'b1;
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        if (byte_cnt_q < PAYLOAD_END) begin
                            out_data_d  = dec_data;
                            out_valid_d = 1'b1;
                        end
                        if (byte_cnt_q == DATA_LAST) begin
                            state_d = ST_FINISH;
                            if (crc_next != 16'h0000) begin
                                status_d = STS_DATA_CRC;
                            end else if (deleted_q) begin
                                status_d = STS_DELETED_OK;
                            end else begin
                                status_d = STS_OK;
                            end
                        end
                    end
                end
            end

            ST_FINISH: begin
                if (!out_valid_q) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides whatever the state decided this cycle.
        if (abort && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            status_d    = STS_NOT_FOUND;
            out_valid_d = 1'b0;
            crc_clear   = 1'b0;
            crc_strobe  = 1'b0;
        end
    end

    // Outputs
    always_comb begin
        dec_enable = (state_q != ST_IDLE);
        busy       = (state_q != ST_IDLE);
        done       = (state_q == ST_FINISH) && !out_valid_q && !abort;
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign status    = status_q;

endmodule
